// File: rtl/sin_lut_arbiter.sv
// sin_lut_arbiter
//   Shares one synchronous sine LUT read port between N_REQ phase-accumulator
//   requesters using round-robin request/grant arbitration. Each LUT sample is
//   returned tagged with the index of the requester that asked for it.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   en         1 = issue new grants; 0 = hold off, in-flight reads complete
//   req        per-requester level request
//   addr_in    request addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//   gnt        registered one-hot grant pulse
//   lut_rd     registered LUT read strobe
//   lut_addr   registered LUT read address (holds when idle)
//   lut_data   LUT read data, valid LUT_LAT cycles after lut_rd
//   rsp_valid  response strobe, LUT_LAT+1 cycles after the grant cycle
//   rsp_id     requester index owning rsp_data (holds when rsp_valid=0)
//   rsp_data   registered LUT sample (holds when rsp_valid=0)
module sin_lut_arbiter #(
  parameter int N_REQ     = 6,
  parameter int ADDR_BITS = 9,
  parameter int SIG_BITS  = 16,
  parameter int LUT_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_BITS-1:0] addr_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       lut_rd,
  output logic [ADDR_BITS-1:0]       lut_addr,
  input  logic [SIG_BITS-1:0]        lut_data,
  output logic                       rsp_valid,
  output logic [2:0]                 rsp_id,
  output logic [SIG_BITS-1:0]        rsp_data
);

  localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int PID_W = 3 * LUT_LAT;

  logic [N_REQ-1:0]     gnt_q,       gnt_d;
  logic                 lut_rd_q,    lut_rd_d;
  logic [ADDR_BITS-1:0] lut_addr_q,  lut_addr_d;
  logic [2:0]           ptr_q,       ptr_d;
  logic [LUT_LAT-1:0]   pv_q,        pv_d;
  logic [PID_W-1:0]     pid_q,       pid_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2:0]           rsp_id_q,    rsp_id_d;
  logic [SIG_BITS-1:0]  rsp_data_q,  rsp_data_d;

  logic [N_REQ-1:0]     elig;
  logic                 found;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;

  // Round-robin search starting one past the last winner; a requester whose
  // grant is currently showing is masked so a held req re-arbitrates next cycle.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    lut_rd_d   = 1'b0;
    lut_addr_d = lut_addr_q;
    ptr_d      = ptr_q;
    if (en && found) begin
      gnt_d[win] = 1'b1;
      lut_rd_d   = 1'b1;
      lut_addr_d = addr_in[win*ADDR_BITS +: ADDR_BITS];
      ptr_d      = 3'(win);
    end
  end

  // Valid/id pipeline tracks the LUT latency. While lut_rd_q is high, ptr_q
  // still holds the index granted in that same cycle, so it serves as the tag.
  always_comb begin
    pv_d        = LUT_LAT'({pv_q, lut_rd_q});
    pid_d       = PID_W'({pid_q, ptr_q});
    rsp_valid_d = pv_q[LUT_LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (pv_q[LUT_LAT-1]) begin
      rsp_id_d   = pid_q[PID_W-1 -: 3];
      rsp_data_d = lut_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      lut_rd_q    <= 1'b0;
      lut_addr_q  <= '0;
      ptr_q       <= 3'(N_REQ - 1);
      pv_q        <= '0;
      pid_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      gnt_q       <= gnt_d;
      lut_rd_q    <= lut_rd_d;
      lut_addr_q  <= lut_addr_d;
      ptr_q       <= ptr_d;
      pv_q        <= pv_d;
      pid_q       <= pid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign lut_rd    = lut_rd_q;
  assign lut_addr  = lut_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
